// File: rtl/apb4_slave_mem.sv
// APB4 completer fronting a word-addressed memory array, with programmable wait states,
// byte-lane writes, error response for bad/read-only/non-secure accesses and protocol-violation flagging.
module apb4_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int RO_START    = DEPTH,
    parameter bit SECURE_ONLY = 1'b0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic                    proto_err
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int IDX_W  = $clog2(DEPTH);

    localparam logic [3:0]            WS         = WAIT_STATES[3:0];
    localparam logic [IDX_W:0]        RO_LIM     = RO_START[IDX_W:0];
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NBYTES - 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic              proto_err_q, proto_err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0] setup_idx;
    logic             setup_unaligned;
    logic             setup_out_of_range;
    logic             setup_read_only;
    logic             setup_non_secure;
    logic             setup_err;
    logic             load;
    logic             ready;
    logic             wr_en;
    logic             unused_pprot;

    assign unused_pprot = &{1'b0, PPROT[2], PPROT[0]};

    // Error classification is done on the live setup-phase address and held for the whole access.
    assign setup_idx          = PADDR[LSB +: IDX_W];
    assign setup_unaligned    = (PADDR & ALIGN_MASK) != '0;
    assign setup_out_of_range = (PADDR >> (LSB + IDX_W)) != '0;
    assign setup_read_only    = PWRITE && ({1'b0, setup_idx} >= RO_LIM);
    assign setup_non_secure   = SECURE_ONLY && PPROT[1];
    assign setup_err          = setup_unaligned || setup_out_of_range ||
                                setup_read_only || setup_non_secure;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        write_d     = write_q;
        err_d       = err_q;
        proto_err_d = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    load    = 1'b1;
                    state_d = ACCESS;
                end else if (PSEL && PENABLE) begin
                    proto_err_d = 1'b1;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (!PENABLE) begin
                    // A fresh setup phase mid-transfer restarts with the new request.
                    proto_err_d = 1'b1;
                    load        = 1'b1;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            idx_d   = setup_idx;
            write_d = PWRITE;
            err_d   = setup_err;
            cnt_d   = WS;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            write_q     <= write_d;
            err_q       <= err_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign ready = (state_q == ACCESS) && (cnt_q == 4'd0) && PSEL && PENABLE;
    assign wr_en = ready && write_q && !err_q;

    always_ff @(posedge PCLK) begin
        for (int b = 0; b < NBYTES; b++) begin
            if (wr_en && PSTRB[b]) begin
                mem[idx_q][b*8 +: 8] <= PWDATA[b*8 +: 8];
            end
        end
    end

    assign PREADY    = ready;
    assign PSLVERR   = ready && err_q;
    assign PRDATA    = (ready && !write_q && !err_q) ? mem[idx_q] : '0;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_apb4_slave_mem.sv
// Directed bench for apb4_slave_mem: three instances (defaults, 3 wait states, RO + secure-only)
// driven by a vector table plus hand-written protocol-violation and reset sequences.
`timescale 1ns/1ps
module tb_apb4_slave_mem;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic [2:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;

   logic [31:0] prdata [3];
   logic        pready [3];
   logic        pslverr [3];
   logic        perr [3];

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      int          sel;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      logic [31:0] expRdata;
      logic        expErr;
      int          expCycles;
   } vec_t;

   vec_t vecs[$];

   always #5 PCLK = ~PCLK;

   apb4_slave_mem u_def (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
      .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .proto_err(perr[0])
   );

   apb4_slave_mem #(.WAIT_STATES(3)) u_ws (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
      .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .proto_err(perr[1])
   );

   apb4_slave_mem #(.RO_START(8), .SECURE_ONLY(1'b1)) u_sec (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
      .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]), .proto_err(perr[2])
   );

   // One comparison: bumps the totals and reports any mismatch on a single line.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Park the bus with nothing selected.
   task automatic idleBus();
      psel    = 3'b000;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
      pprot   = '0;
   endtask

   // Counts access-phase cycles until PREADY, sampling mid-cycle; 99 marks a timeout.
   task automatic waitReady(input int s, output int n);
      n = 1;
      @(negedge PCLK);
      while (!pready[s] && n < 20) begin
         @(negedge PCLK);
         n++;
      end
      if (!pready[s]) n = 99;
   endtask

   // Full setup+access transfer on instance s; cycles includes the setup cycle.
   task automatic applyStimulus(input int s, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                input logic [2:0] prot, output logic [31:0] rdata,
                                output logic err, output int cycles);
      int n;
      @(posedge PCLK); #1;
      psel    = 3'b000;
      psel[s] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      pstrb   = strb;
      pprot   = prot;
      @(posedge PCLK); #1;
      penable = 1'b1;
      waitReady(s, n);
      rdata  = prdata[s];
      err    = pslverr[s];
      cycles = n + 1;
      @(posedge PCLK); #1;
      idleBus();
   endtask

   function automatic void addVec(input string name, input int sel, input logic wr,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] strb, input logic [2:0] prot,
                                  input logic [31:0] expRdata, input logic expErr,
                                  input int expCycles);
      vec_t v;
      v.name = name; v.sel = sel; v.wr = wr; v.addr = addr; v.wdata = wdata;
      v.strb = strb; v.prot = prot; v.expRdata = expRdata; v.expErr = expErr;
      v.expCycles = expCycles;
      vecs.push_back(v);
   endfunction

   // Safety net so a wedged DUT still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          cyc;
      int          n;

      // Default instance: basic write/read, strobes, range/alignment errors, boundary word.
      addVec("wr_10",       0, 1, 32'h010, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0,        0, 2);
      addVec("rd_10",       0, 0, 32'h010, 32'h0,        4'h0, 3'b000, 32'hDEADBEEF, 0, 2);
      addVec("wr_20_full",  0, 1, 32'h020, 32'hFFFFFFFF, 4'hF, 3'b000, 32'h0,        0, 2);
      addVec("wr_20_strb",  0, 1, 32'h020, 32'h11223344, 4'h5, 3'b000, 32'h0,        0, 2);
      addVec("rd_20",       0, 0, 32'h020, 32'h0,        4'h0, 3'b000, 32'hFF22FF44, 0, 2);
      addVec("rd_oor",      0, 0, 32'h400, 32'h0,        4'h0, 3'b000, 32'h0,        1, 2);
      addVec("rd_unalign",  0, 0, 32'h002, 32'h0,        4'h0, 3'b000, 32'h0,        1, 2);
      addVec("wr_00",       0, 1, 32'h000, 32'hCAFEF00D, 4'hF, 3'b000, 32'h0,        0, 2);
      addVec("wr_oor",      0, 1, 32'h400, 32'h12345678, 4'hF, 3'b000, 32'h0,        1, 2);
      addVec("rd_00",       0, 0, 32'h000, 32'h0,        4'h0, 3'b000, 32'hCAFEF00D, 0, 2);
      addVec("wr_unalign",  0, 1, 32'h012, 32'h00000000, 4'hF, 3'b000, 32'h0,        1, 2);
      addVec("rd_10_keep",  0, 0, 32'h010, 32'h0,        4'hF, 3'b000, 32'hDEADBEEF, 0, 2);
      addVec("wr_24",       0, 1, 32'h024, 32'h55667788, 4'hF, 3'b000, 32'h0,        0, 2);
      addVec("wr_24_nostb", 0, 1, 32'h024, 32'hAABBCCDD, 4'h0, 3'b000, 32'h0,        0, 2);
      addVec("rd_24",       0, 0, 32'h024, 32'h0,        4'h0, 3'b000, 32'h55667788, 0, 2);
      addVec("wr_last",     0, 1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 3'b000, 32'h0,        0, 2);
      addVec("wr_last_lo",  0, 1, 32'h3FC, 32'h12345678, 4'h3, 3'b000, 32'h0,        0, 2);
      addVec("rd_last",     0, 0, 32'h3FC, 32'h0,        4'h0, 3'b000, 32'hA5A55678, 0, 2);
      addVec("rd_nonsec_ok",0, 0, 32'h010, 32'h0,        4'h0, 3'b010, 32'hDEADBEEF, 0, 2);
      // Wait-state instance: every transfer, including errors, takes 5 cycles.
      addVec("ws_wr_00",    1, 1, 32'h000, 32'h13579BDF, 4'hF, 3'b000, 32'h0,        0, 5);
      addVec("ws_rd_00",    1, 0, 32'h000, 32'h0,        4'h0, 3'b000, 32'h13579BDF, 0, 5);
      addVec("ws_rd_err",   1, 0, 32'h002, 32'h0,        4'h0, 3'b000, 32'h0,        1, 5);
      addVec("ws_wr_04",    1, 1, 32'h004, 32'hAAAA0000, 4'hF, 3'b000, 32'h0,        0, 5);
      // Read-only from word 8 and secure-only instance.
      addVec("sec_wr_1c",   2, 1, 32'h01C, 32'h01020304, 4'hF, 3'b000, 32'h0,        0, 2);
      addVec("sec_wr_ro",   2, 1, 32'h020, 32'hFFFFFFFF, 4'hF, 3'b000, 32'h0,        1, 2);
      addVec("sec_wr_ns",   2, 1, 32'h01C, 32'h99999999, 4'hF, 3'b010, 32'h0,        1, 2);
      addVec("sec_rd_ns",   2, 0, 32'h01C, 32'h0,        4'h0, 3'b010, 32'h0,        1, 2);
      addVec("sec_rd_1c",   2, 0, 32'h01C, 32'h0,        4'h0, 3'b000, 32'h01020304, 0, 2);
      addVec("sec_rd_prot1",2, 0, 32'h01C, 32'h0,        4'h0, 3'b001, 32'h01020304, 0, 2);

      // Reset state, with select and enable held high to show they are ignored.
      idleBus();
      PRESETn = 1'b0;
      repeat (2) @(posedge PCLK);
      #1;
      psel    = 3'b111;
      penable = 1'b1;
      @(negedge PCLK);
      checkOutput("rst_pready",    pready[0],  32'h0);
      checkOutput("rst_pslverr",   pslverr[0], 32'h0);
      checkOutput("rst_prdata",    prdata[0],  32'h0);
      checkOutput("rst_proto_err", perr[0],    32'h0);
      checkOutput("rst_ws_pready", pready[1],  32'h0);
      idleBus();
      @(negedge PCLK);
      PRESETn = 1'b1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                       vecs[i].prot, rd, er, cyc);
         checkOutput({vecs[i].name, "_rdata"},  rd,                32'(vecs[i].expRdata));
         checkOutput({vecs[i].name, "_err"},    32'(er),           32'(vecs[i].expErr));
         checkOutput({vecs[i].name, "_cycles"}, 32'(cyc),          32'(vecs[i].expCycles));
      end

      // PENABLE asserted with no setup phase: no response, one-cycle violation pulse.
      @(posedge PCLK); #1;
      psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h010; pwdata = 32'h0; pstrb = 4'hF;
      @(negedge PCLK);
      checkOutput("noset_pready", pready[0], 32'h0);
      @(posedge PCLK); #1;
      idleBus();
      @(negedge PCLK);
      checkOutput("noset_pulse_hi", perr[0], 32'h1);
      @(negedge PCLK);
      checkOutput("noset_pulse_lo", perr[0], 32'h0);
      applyStimulus(0, 0, 32'h010, 32'h0, 4'h0, 3'b000, rd, er, cyc);
      checkOutput("noset_rd_10", rd, 32'hDEADBEEF);
      checkOutput("noset_rd_cycles", 32'(cyc), 32'd2);

      // PSEL dropped after one wait cycle on the wait-state instance.
      @(posedge PCLK); #1;
      psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h000; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
      @(posedge PCLK); #1;
      penable = 1'b1;
      @(negedge PCLK);
      checkOutput("abort_wait_pready", pready[1], 32'h0);
      @(posedge PCLK); #1;
      idleBus();
      @(negedge PCLK);
      checkOutput("abort_pre_pulse", perr[1], 32'h0);
      @(negedge PCLK);
      checkOutput("abort_pulse_hi", perr[1], 32'h1);
      checkOutput("abort_pready", pready[1], 32'h0);
      @(negedge PCLK);
      checkOutput("abort_pulse_lo", perr[1], 32'h0);
      applyStimulus(1, 0, 32'h000, 32'h0, 4'h0, 3'b000, rd, er, cyc);
      checkOutput("abort_rd_00", rd, 32'h13579BDF);

      // New setup during a wait-state access: old write dropped, new one runs full length.
      @(posedge PCLK); #1;
      psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h004; pwdata = 32'h11111111; pstrb = 4'hF;
      @(posedge PCLK); #1;
      penable = 1'b1;
      @(posedge PCLK); #1;
      penable = 1'b0; paddr = 32'h008; pwdata = 32'h22222222;
      @(posedge PCLK); #1;
      penable = 1'b1;
      #1;
      checkOutput("resetup_pulse", perr[1], 32'h1);
      waitReady(1, n);
      checkOutput("resetup_access_cycles", 32'(n), 32'd4);
      checkOutput("resetup_err", pslverr[1], 32'h0);
      @(posedge PCLK); #1;
      idleBus();
      applyStimulus(1, 0, 32'h004, 32'h0, 4'h0, 3'b000, rd, er, cyc);
      checkOutput("resetup_rd_04", rd, 32'hAAAA0000);
      applyStimulus(1, 0, 32'h008, 32'h0, 4'h0, 3'b000, rd, er, cyc);
      checkOutput("resetup_rd_08", rd, 32'h22222222);

      // Reset pulled in the completion cycle of a write: outputs drop at once, no write lands.
      @(posedge PCLK); #1;
      psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h010; pwdata = 32'h00000000; pstrb = 4'hF;
      @(posedge PCLK); #1;
      penable = 1'b1;
      #1;
      checkOutput("midrst_pre_pready", pready[0], 32'h1);
      PRESETn = 1'b0;
      #1;
      checkOutput("midrst_pready",  pready[0],  32'h0);
      checkOutput("midrst_pslverr", pslverr[0], 32'h0);
      checkOutput("midrst_prdata",  prdata[0],  32'h0);
      @(posedge PCLK);
      @(negedge PCLK);
      checkOutput("midrst_proto_err", perr[0], 32'h0);
      idleBus();
      PRESETn = 1'b1;
      applyStimulus(0, 0, 32'h010, 32'h0, 4'h0, 3'b000, rd, er, cyc);
      checkOutput("midrst_rd_10", rd, 32'hDEADBEEF);
      checkOutput("midrst_rd_err", 32'(er), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
